// File: rtl/g2b_rr_scheduler.sv
// g2b_rr_scheduler: round-robin scheduler sharing one gray-to-binary converter
// among NREQ requesters. The winner's code is converted and held in a single
// output register. That register is drained through a valid/ready handshake,
// and each result is tagged with the ID of the requester that produced it.
// Optional build macro G2B_STATS_EN adds a saturating 16-bit accept counter
// on port conv_count.
module g2b_rr_scheduler #(
    parameter  int WIDTH = 4,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] gray_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_binary,
    output logic [IDW-1:0]        out_id,
    input  logic                  out_ready
`ifdef G2B_STATS_EN
    ,
    output logic [15:0]           conv_count
`endif
);

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [IDW-1:0]   ptr_p0;
    logic [IDW-1:0]   ptr_nxt;
    logic [IDW-1:0]   idx;
    logic [IDW-1:0]   win_id;
    logic             win_found;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] win_gray;
    logic             vld_p0;
    logic [WIDTH-1:0] binary_p0;
    logic [IDW-1:0]   id_p0;

    // Round-robin search: scan from the pointer upward with wrap; first request wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr_p0) + k) % NREQ);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign can_load = !vld_p0 || out_ready;
    assign accept   = can_load && win_found && !rst;
    assign win_gray = gray_in[int'(win_id)*WIDTH +: WIDTH];
    assign ptr_nxt  = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;

    // One-hot grant for the winner, only when the output register can take a result.
    always_comb begin
        gnt = '0;
        if (accept) begin
            gnt[win_id] = 1'b1;
        end
    end

    // ---- stage p0: output register and round-robin pointer ----
    // Load on accept (replacing any result draining this edge), otherwise empty on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            binary_p0 <= '0;
            id_p0     <= '0;
            ptr_p0    <= '0;
        end else if (accept) begin
            vld_p0    <= 1'b1;
            binary_p0 <= g2b(win_gray);
            id_p0     <= win_id;
            ptr_p0    <= ptr_nxt;
        end else if (vld_p0 && out_ready) begin
            vld_p0    <= 1'b0;
        end
    end

    assign out_valid  = vld_p0;
    assign out_binary = binary_p0;
    assign out_id     = id_p0;

`ifdef G2B_STATS_EN
    logic [15:0] count_p0;

    // Count accepted conversions, holding at the maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_p0 <= '0;
        end else if (accept) begin
            count_p0 <= sat_inc(count_p0);
        end
    end

    assign conv_count = count_p0;
`endif

endmodule

// File: doc/g2b_rr_scheduler.md
Name: g2b_rr_scheduler

Overview:
Round-robin scheduler that shares one gray-to-binary conversion datapath among NREQ requesters. Each requester presents a gray code with a req/gnt handshake. The scheduler grants one requester per accept cycle, registers the binary result, and emits it on a single valid/ready output tagged with the requester ID. It sits between gray-coded sources (e.g. pointer or encoder samplers) and a single consumer.

Parameters:
WIDTH, 4, code width in bits (>=2)
NREQ, 4, number of requesters (>=2)
IDW, $clog2(NREQ), requester-ID width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  NREQ  per-requester request; bit i = requester i has a code pending
gray_in  input  NREQ*WIDTH  flattened codes; requester i at bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot combinational grant; bit i high = requester i accepted at this edge
out_valid  output  1  result valid
out_binary  output  WIDTH  converted binary value
out_id  output  IDW  index of the requester that produced out_binary
out_ready  input  1  consumer accepts the result at this edge when high with out_valid

Behaviour:
- Conversion rule: binary[k] = XOR of gray[WIDTH-1:k], for k = 0..WIDTH-1.
- Reset (async, immediate): out_valid=0, out_binary=0, out_id=0, rr pointer=0. gnt is driven 0 while rst is high.
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_load = !out_valid || out_ready.
- Accept: when can_load and |req, gnt is one-hot for the winner w in the same cycle. At the edge:
  - out_binary <= conv(gray_in[w]), out_id <= w, out_valid <= 1.
  - rr pointer <= (w+1) mod NREQ.
- Arbitration: search from rr pointer upward with wrap. The first asserted req wins. The rr pointer changes only on an accept.
- Drain: out_valid && out_ready && no accept → out_valid <= 0 (EMPTY). out_binary and out_id hold their last values.
- Simultaneous drain and accept: the output is replaced in the same edge. Throughput is 1 result per cycle, with no bubble.
- Backpressure: out_valid && !out_ready → gnt=0. out_binary, out_id and out_valid stay stable.
- Latency: accept edge → out_valid high from that edge. This is 1 cycle from the gnt cycle.
- Requester contract:
  - req and gray_in[i] are held stable until gnt[i] is seen.
  - Deasserting req without a grant is permitted; that code is simply never converted.
- req=0 everywhere → gnt=0 and no state change, apart from a possible drain.
- Reset mid-operation discards the pending result without an out_valid pulse.

Optional Feature:
Macro G2B_STATS_EN.
- Defined: adds output port conv_count [15:0].
  - Increments by 1 on every accept edge.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then a single requester.
   - Stimulus: req=0001, gray0=4'b1110, out_ready=1.
   - Response: gnt=0001 in that cycle. Next cycle out_valid=1, out_binary=4'b1011, out_id=0.
2. All requests held continuously, out_ready=1.
   - Stimulus: gray0..3 = 0100, 0111, 1010, 1000.
   - Response: grants in order 0,1,2,3,0. Results 0111, 0101, 1100, 1111 on back-to-back cycles with no gap.
3. Backpressure.
   - Stimulus: out_ready=0 for 3 cycles while req=0110.
   - Response: gnt=0 and output frozen for those cycles. On out_ready=1, the held result drains and the next grant goes to requester 1 (then 2) in the same edge.
4. Wrap and fairness.
   - Stimulus: last grant to requester 3, then req=1001.
   - Response: next grant goes to 0 (pointer wrapped), then 3.
5. Async reset.
   - Stimulus: assert rst mid-cycle while out_valid=1.
   - Response: out_valid drops immediately with no clock edge. After release, the first grant goes to the lowest active requester.
6. With G2B_STATS_EN defined.
   - Stimulus: 5 accepts.
   - Response: conv_count=5. Forced near saturation, conv_count stays at FFFF.
